// File: rtl/vga_pkg.sv
// Shared VGA timing constants, capture FSM encoding and the frame-buffer address helper.
package vga_pkg;

    localparam int H_TOTAL     = 800;
    localparam int H_VIS_START = 144;
    localparam int H_VIS       = 640;
    localparam int V_TOTAL     = 525;
    localparam int V_VIS_START = 35;
    localparam int V_VIS       = 480;

    localparam int CNT_W  = 10;
    localparam int ADDR_W = 17;
    localparam int PIX_W  = 12;

    localparam logic [CNT_W-1:0] CNT_MAX = 10'd1023;
    localparam logic [CNT_W-1:0] CNT_PRE = 10'd1022;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_CAPTURE = 2'd3
    } cap_state_e;

    // Half-resolution word address: yh*320 + xh built as yh*256 + yh*64 + xh.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [8:0] xh, input logic [8:0] yh);
        logic [ADDR_W-1:0] y17;
        y17 = {8'd0, yh};
        return (y17 << 8) + (y17 << 6) + {8'd0, xh};
    endfunction

endpackage

// File: rtl/vga_sync_tracker.sv
// Sync edge detection, horizontal/vertical position counters and timing-violation flags.
module vga_sync_tracker #(
    parameter int H_TOTAL = vga_pkg::H_TOTAL,
    parameter int V_TOTAL = vga_pkg::V_TOTAL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync,
    input  logic       vsync,
    output logic       v_fall,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       h_bad,
    output logic       v_bad
);
    import vga_pkg::*;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       h_fall;

    assign h_fall = hs_q & ~hsync;
    assign v_fall = vs_q & ~vsync;

    always_comb begin
        hs_d    = hsync;
        vs_d    = vsync;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (h_fall) begin
            h_cnt_d = '0;
        end else if (h_cnt_q != CNT_MAX) begin
            h_cnt_d = h_cnt_q + 10'd1;
        end
        if (v_fall) begin
            v_cnt_d = '0;
        end else if (h_fall && (v_cnt_q != CNT_MAX)) begin
            v_cnt_d = v_cnt_q + 10'd1;
        end
    end

    // Saturation is flagged once, on the step into 1023, so a dead hsync reports a single error.
    assign h_bad = (h_fall && (h_cnt_q != H_LAST)) || (!h_fall && (h_cnt_q == CNT_PRE));
    assign v_bad = v_fall && (v_cnt_q != V_LAST);

    assign h_cnt = h_cnt_q;
    assign v_cnt = v_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

endmodule

// File: rtl/vga_capture.sv
// Locks onto incoming VGA timing and, on request, writes one decimated 320x240 frame to memory.
module vga_capture #(
    parameter int H_TOTAL     = vga_pkg::H_TOTAL,
    parameter int H_VIS_START = vga_pkg::H_VIS_START,
    parameter int H_VIS       = vga_pkg::H_VIS,
    parameter int V_TOTAL     = vga_pkg::V_TOTAL,
    parameter int V_VIS_START = vga_pkg::V_VIS_START,
    parameter int V_VIS       = vga_pkg::V_VIS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
    input  logic        capture_req,
    output logic        wr_en,
    output logic [16:0] wr_addr,
    output logic [11:0] wr_data,
    output logic        locked,
    output logic        frame_done,
    output logic        err
);
    import vga_pkg::*;

    localparam logic [9:0] H_LO = 10'(H_VIS_START);
    localparam logic [9:0] H_HI = 10'(H_VIS_START + H_VIS);
    localparam logic [9:0] V_LO = 10'(V_VIS_START);
    localparam logic [9:0] V_HI = 10'(V_VIS_START + V_VIS);

    logic       v_fall, h_bad, v_bad, viol, pix_ok;
    logic [9:0] h_cnt, v_cnt, x, y;

    cap_state_e  state_q, state_d;
    logic        pend_q, pend_d;
    logic        locked_q, locked_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        wr_en_q, wr_en_d;
    logic [16:0] wr_addr_q, wr_addr_d;
    logic [11:0] wr_data_q, wr_data_d;

    vga_sync_tracker #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_tracker (
        .clk    (clk),
        .rst    (rst),
        .hsync  (hsync),
        .vsync  (vsync),
        .v_fall (v_fall),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .h_bad  (h_bad),
        .v_bad  (v_bad)
    );

    assign viol = h_bad | v_bad;
    assign x    = h_cnt - H_LO;
    assign y    = v_cnt - V_LO;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q | capture_req;
        err_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (v_fall) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (viol) begin
                    state_d = ST_HUNT;
                    err_d   = 1'b1;
                end else if (v_fall) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (viol) begin
                    state_d = ST_HUNT;
                    err_d   = 1'b1;
                end else if (v_fall && pend_q) begin
                    state_d = ST_CAPTURE;
                    pend_d  = capture_req;
                end
            end
            ST_CAPTURE: begin
                // A request held during capture chains straight into the next frame.
                if (viol) begin
                    state_d = ST_HUNT;
                    err_d   = 1'b1;
                end else if (v_fall) begin
                    done_d = 1'b1;
                    if (pend_q) begin
                        pend_d = capture_req;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase

        locked_d = (state_d == ST_LOCKED) || (state_d == ST_CAPTURE);

        pix_ok = (state_q == ST_CAPTURE) && !viol
               && (h_cnt >= H_LO) && (h_cnt < H_HI)
               && (v_cnt >= V_LO) && (v_cnt < V_HI)
               && !x[0] && !y[0];

        wr_en_d   = pix_ok;
        wr_addr_d = pix_ok ? pix_addr(x[9:1], y[9:1]) : wr_addr_q;
        wr_data_d = pix_ok ? rgb : wr_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_HUNT;
            pend_q    <= 1'b0;
            locked_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            locked_q  <= locked_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign locked     = locked_q;
    assign frame_done = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture using a shrunken 40x20 raster (16x8 visible) to keep frames short.
module tb_vga_capture;

    localparam int HT = 40;
    localparam int HS = 6;
    localparam int HV = 16;
    localparam int VT = 20;
    localparam int VS = 3;
    localparam int VV = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic        capture_req;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic [11:0] wr_data;
    logic        locked;
    logic        frame_done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int seen_first = 0;
    int seen_last  = 0;
    int mon_addr;

    vga_capture #(
        .H_TOTAL     (HT),
        .H_VIS_START (HS),
        .H_VIS       (HV),
        .V_TOTAL     (VT),
        .V_VIS_START (VS),
        .V_VIS       (VV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .capture_req (capture_req),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .locked      (locked),
        .frame_done  (frame_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pixel driven at line cycle c of line l; visible (x,y) sits at c = x+7, l = y+3.
    function automatic logic [11:0] pix_val(input int c, input int l);
        if (c == 7 && l == 3)  return 12'hF00;
        if (c == 21 && l == 9) return 12'h0AB;
        return {4'(l), 8'(c)};
    endfunction

    always @(negedge clk) begin
        if (wr_en) begin
            mon_addr = int'(wr_addr);
            wr_cnt++;
            check("wr_addr_range", 32'((mon_addr % 320 < 8) && (mon_addr / 320 < 4)), 32'd1);
            check("wr_data", 32'(wr_data),
                  32'(pix_val(2 * (mon_addr % 320) + 7, 2 * (mon_addr / 320) + 3)));
            if (mon_addr == 0)   seen_first++;
            if (mon_addr == 967) seen_last++;
            $display("write addr=%0d data=%03h", mon_addr, wr_data);
        end
        if (frame_done) done_cnt++;
        if (err) err_cnt++;
    end

    task automatic drive_line(input int l, input int len, input bit vs_low, input int req_at, input int rst_at);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            if (rst_at >= 0 && c == rst_at + 1) begin
                check("rst_wr_en", 32'(wr_en), 32'd0);
                check("rst_locked", 32'(locked), 32'd0);
            end
            hsync       = (c < 4) ? 1'b0 : 1'b1;
            vsync       = vs_low ? 1'b0 : 1'b1;
            rgb         = pix_val(c, l);
            capture_req = (c == req_at);
            rst         = (rst_at >= 0) && (c == rst_at || c == rst_at + 1);
        end
    endtask

    task automatic drive_frame(input string name, input int long_line, input int req_line, input int rst_line);
        for (int l = 0; l < VT; l++) begin
            drive_line(l, (l == long_line) ? HT + 1 : HT, l < 2,
                       (l == req_line) ? 10 : -1, (l == rst_line) ? 15 : -1);
        end
        $display("frame %s: locked=%0d writes=%0d done=%0d errs=%0d", name, locked, wr_cnt, done_cnt, err_cnt);
    endtask

    task automatic hold_high(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hsync       = 1'b1;
            vsync       = 1'b1;
            capture_req = 1'b0;
        end
        $display("hsync held high %0d clocks: locked=%0d errs=%0d", n, locked, err_cnt);
    endtask

    initial begin
        rst = 1'b1; hsync = 1'b1; vsync = 1'b1; rgb = '0; capture_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_en_idle", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_locked_idle", 32'(locked), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        drive_frame("F1", -1, -1, -1);
        check("f1_locked", 32'(locked), 32'd0);
        drive_frame("F2", -1, 15, -1);
        check("f2_locked", 32'(locked), 32'd1);
        check("f2_writes", wr_cnt, 0);
        drive_frame("F3", -1, 5, -1);
        check("f3_writes", wr_cnt, 32);
        check("f3_done", done_cnt, 0);
        check("f3_first_px", seen_first, 1);
        check("f3_last_px", seen_last, 1);
        drive_frame("F4", -1, -1, -1);
        check("f4_writes", wr_cnt, 64);
        check("f4_done", done_cnt, 1);
        check("f4_locked", 32'(locked), 32'd1);
        drive_frame("F5", -1, -1, -1);
        check("f5_writes", wr_cnt, 64);
        check("f5_done", done_cnt, 2);
        check("f5_errs", err_cnt, 0);

        drive_frame("F6_long_line", 8, -1, -1);
        check("long_line_err", err_cnt, 1);
        check("long_line_locked", 32'(locked), 32'd0);
        drive_frame("F7", -1, -1, -1);
        check("relock_f7_locked", 32'(locked), 32'd0);
        check("relock_f7_errs", err_cnt, 1);
        drive_frame("F8", -1, -1, -1);
        check("relock_f8_locked", 32'(locked), 32'd1);

        hold_high(1100);
        check("dead_hsync_err", err_cnt, 2);
        check("dead_hsync_locked", 32'(locked), 32'd0);
        drive_frame("F9", -1, -1, -1);
        check("f9_locked", 32'(locked), 32'd0);
        check("f9_errs", err_cnt, 2);
        drive_frame("F10", -1, 5, -1);
        check("f10_locked", 32'(locked), 32'd1);

        drive_frame("F11_rst", -1, -1, 5);
        check("f11_done", done_cnt, 2);
        check("f11_locked", 32'(locked), 32'd0);
        drive_frame("F12", -1, -1, -1);
        check("f12_locked", 32'(locked), 32'd0);
        drive_frame("F13", -1, -1, -1);
        check("f13_locked", 32'(locked), 32'd1);
        check("f13_done", done_cnt, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
